// File: rtl/twiddle_stream_sequencer_if.sv
// Stream, multiplier and frame-done bundle for twiddle_stream_sequencer.
// The inv signal exists only when TWIDDLE_STREAM_IFFT_CONJ_EN is defined.
interface twiddle_stream_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_idx;
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
  logic        inv;
`endif
  logic [31:0] mul_a32;
  logic [2:0]  mul_typesel;
  logic [2:0]  mul_base;
  logic [31:0] mul_r32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        frame_done;

  modport slave (
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
    input  inv,
`endif
    input  in_valid, in_data, in_idx, mul_r32, out_ready,
    output in_ready, mul_a32, mul_typesel, mul_base, out_valid, out_data, frame_done
  );

  modport master (
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
    output inv,
`endif
    output in_valid, in_data, in_idx, mul_r32, out_ready,
    input  in_ready, mul_a32, mul_typesel, mul_base, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/twiddle_stream_sequencer.sv
// Two-stage operand/result pipeline around the combinational twiddle multiplier, with frame FSM.
// Define TWIDDLE_STREAM_IFFT_CONJ_EN to add the inv input (conjugate twiddle for IFFT).
module twiddle_stream_sequencer #(
  parameter int STAGE     = 0,
  parameter int FRAME_LEN = 64
) (
  input logic                       clk,
  input logic                       rst_n,
  twiddle_stream_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [6:0] CNT_LAST = 7'(FRAME_LEN - 1);

  state_t     state;
  logic [6:0] in_cnt;
  logic [6:0] out_cnt;
  logic       s1_valid;
  logic       in_ready;
  logic       in_xfer;
  logic       out_xfer;
  logic       s2_load;
  logic       last_out;
  logic [5:0] e_raw;
  logic [5:0] e_use;

  // (k mod 2^(6-STAGE)) << STAGE is exactly the low 6 bits of k << STAGE
  assign e_raw = bus.in_idx << STAGE;
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
  assign e_use = bus.inv ? (6'd0 - e_raw) : e_raw;
`else
  assign e_use = e_raw;
`endif

  assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
  assign in_ready     = (state == RUN) && (!s1_valid || s2_load);
  assign bus.in_ready = in_ready;
  assign in_xfer      = bus.in_valid && in_ready;
  assign out_xfer     = bus.out_valid && bus.out_ready;
  assign last_out     = out_xfer && (out_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid        <= 1'b0;
      bus.mul_a32     <= '0;
      bus.mul_typesel <= '0;
      bus.mul_base    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid        <= 1'b1;
        bus.mul_a32     <= bus.in_data;
        bus.mul_typesel <= e_use[5:3];
        bus.mul_base    <= e_use[2:0];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.mul_r32;
      end else if (out_xfer) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      in_cnt         <= '0;
      out_cnt        <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (out_xfer) out_cnt <= last_out ? 7'd0 : out_cnt + 7'd1;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (in_xfer) begin
            if (in_cnt == CNT_LAST) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end else begin
              in_cnt <= in_cnt + 7'd1;
            end
          end
        end
        DRAIN: begin
          // input is blocked here, so only this frame's tail is in flight
          if (last_out) begin
            bus.frame_done <= 1'b1;
            in_cnt         <= '0;
            out_cnt        <= '0;
            state          <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twiddle_stream_sequencer.sv
// Scoreboard bench: three sequencers (STAGE 0/3/5) share one stimulus stream; a stand-in
// multiplier returns a32 + {typesel,base}, so each output carries data plus the exponent.
module tb_twiddle_stream_sequencer;
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    longint      t;
    bit          last;
  } exp_t;

  typedef struct {
    logic [5:0] idx;
    logic       inv;
    logic [5:0] e0, e3, e5;
  } dv_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_idx;
  logic        inv;
  logic        out_ready;

  int n_vec = 0;
  int miss = 0;
  int n_xfer = 0;
  int cyc_cnt = 0;
  bit chk_lat = 1'b0;
  int pend[3];
  int n_fd[3];
  logic [2:0] rdy;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_e(input int st, input logic [5:0] idx, input logic iv);
    int m, e;
    m = 64 >> st;
    e = (int'(idx) % m) * (1 << st);
    e = e % 64;
    if (iv && CONJ) e = (64 - e) % 64;
    return e[5:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_st
    localparam int ST = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    twiddle_stream_sequencer_if bus();
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_idx    = in_idx;
    assign bus.out_ready = out_ready;
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
    assign bus.inv       = inv;
`endif
    assign bus.mul_r32   = bus.mul_a32 + {26'd0, bus.mul_typesel, bus.mul_base};
    assign rdy[g]        = bus.in_ready;

    twiddle_stream_sequencer #(.STAGE(ST), .FRAME_LEN(64)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    exp_t q[$];
    int   pushed = 0;
    bit   fd_exp = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        pushed = 0;
        fd_exp = 1'b0;
        pend[g] = 0;
      end else begin
        if (fd_exp || bus.frame_done) chk($sformatf("frame_done s%0d", ST), 32'(bus.frame_done), 32'(fd_exp));
        if (bus.frame_done) n_fd[g]++;
        fd_exp = 1'b0;
        if (bus.out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("spurious out s%0d", ST), bus.out_data, 32'hxxxx_xxxx);
          end else begin
            exp_t e;
            e = q.pop_front();
            pend[g]--;
            chk($sformatf("out_data s%0d", ST), bus.out_data, e.d);
            if (chk_lat) chk($sformatf("latency s%0d", ST), 32'(($time - e.t) / 10), 32'd2);
            fd_exp = e.last;
          end
        end
        if (in_valid && bus.in_ready) begin
          exp_t e;
          e.d    = in_data + {26'd0, exp_e(ST, in_idx, inv)};
          e.t    = longint'($time);
          e.last = (pushed == 63);
          q.push_back(e);
          pend[g]++;
          pushed = (pushed == 63) ? 0 : pushed + 1;
          if (g == 0) n_xfer++;
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},   32'(g_st[0].bus.in_ready),    32'd0);
    chk({tag, " mul_a32"},    g_st[0].bus.mul_a32,          32'd0);
    chk({tag, " typesel"},    32'(g_st[0].bus.mul_typesel), 32'd0);
    chk({tag, " base"},       32'(g_st[0].bus.mul_base),    32'd0);
    chk({tag, " out_valid"},  32'(g_st[0].bus.out_valid),   32'd0);
    chk({tag, " out_data"},   g_st[0].bus.out_data,         32'd0);
    chk({tag, " frame_done"}, 32'(g_st[0].bus.frame_done),  32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) n_fd[i] = 0;
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_idx = idx; in_data = d; in_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (!rst_n) break;
      cyc_cnt++;
      if (rdy[0]) begin ok = 1'b1; break; end
    end
    if (!ok && rst_n) chk("in_ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input bit fixed);
    for (int k = 0; k < n; k++) begin
      if (!rst_n) break;
      send(6'(k % 64), fixed ? base : base + 32'((k << 16) | k));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int fds);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s pending s%0d", tag, i), 32'(pend[i]), 32'd0);
      chk($sformatf("%s frame_done count s%0d", tag, i), 32'(n_fd[i]), 32'(fds));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dv_t dv[$];
    int  base_x;
    logic [31:0] snap_d, snap_m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_idx = '0; inv = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin pend[i] = 0; n_fd[i] = 0; end
    #1 chk_reset_vals("reset");

    // full frame at STAGE 0 with constant data: exponent follows k, latency 2
    do_reset();
    chk_lat = 1'b1;
    send_frame(64, 32'h4000_0000, 1'b1);
    drain_check("frame", 1);
    chk_lat = 1'b0;

    // hand-computed exponents for all three stages
    dv.push_back('{6'd13, 1'b0, 6'd13, 6'd40, 6'd32});
    dv.push_back('{6'd5,  1'b0, 6'd5,  6'd40, 6'd32});
    dv.push_back('{6'd0,  1'b0, 6'd0,  6'd0,  6'd0});
    dv.push_back('{6'd63, 1'b0, 6'd63, 6'd56, 6'd32});
    dv.push_back('{6'd6,  1'b0, 6'd6,  6'd48, 6'd0});
`ifdef TWIDDLE_STREAM_IFFT_CONJ_EN
    dv.push_back('{6'd5,  1'b1, 6'd59, 6'd24, 6'd32});
    dv.push_back('{6'd13, 1'b1, 6'd51, 6'd24, 6'd32});
    dv.push_back('{6'd0,  1'b1, 6'd0,  6'd0,  6'd0});
`endif
    do_reset();
    foreach (dv[i]) begin
      inv = dv[i].inv;
      send(dv[i].idx, 32'h0100_0000 + 32'(i));
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("e s0 idx%0d inv%0d", dv[i].idx, dv[i].inv),
          32'({g_st[0].bus.mul_typesel, g_st[0].bus.mul_base}), 32'(dv[i].e0));
      chk($sformatf("e s3 idx%0d inv%0d", dv[i].idx, dv[i].inv),
          32'({g_st[1].bus.mul_typesel, g_st[1].bus.mul_base}), 32'(dv[i].e3));
      chk($sformatf("e s5 idx%0d inv%0d", dv[i].idx, dv[i].inv),
          32'({g_st[2].bus.mul_typesel, g_st[2].bus.mul_base}), 32'(dv[i].e5));
      @(posedge clk); #1;
    end
    inv = 1'b0;
    drain_check("directed", 0);

    // backpressure: two samples fill the pipe, then everything holds
    do_reset();
    out_ready = 1'b0;
    base_x = n_xfer;
    fork
      send_frame(64, 32'h1234_0000, 1'b0);
      begin
        repeat (3) @(negedge clk);
        #1;
        snap_d = g_st[0].bus.out_data;
        snap_m = g_st[0].bus.mul_a32;
        repeat (2) @(negedge clk);
        #1;
        chk("stall accepted", 32'(n_xfer - base_x), 32'd2);
        chk("stall in_ready", 32'(rdy), 32'd0);
        chk("stall out_data", g_st[0].bus.out_data, snap_d);
        chk("stall mul_a32", g_st[0].bus.mul_a32, snap_m);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain_check("stall", 1);

    // reset at sample 20: immediate clear, no frame_done, next frame from 0
    do_reset();
    base_x = n_xfer;
    fork
      send_frame(64, 32'h0abc_0000, 1'b0);
      begin
        for (int w = 0; w < 500 && (n_xfer - base_x) < 20; w++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
      end
    join
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset frame_done count", 32'(n_fd[0]), 32'd0);
    send_frame(64, 32'h0def_0000, 1'b0);
    drain_check("after reset", 1);

    // sustained streaming over three frames: 64 per frame plus a 2-cycle gap
    do_reset();
    cyc_cnt = 0;
    send_frame(192, 32'h2000_0000, 1'b0);
    chk("sustained cycles", 32'(cyc_cnt), 32'd196);
    drain_check("sustained", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end
endmodule

// File: doc/twiddle_stream_sequencer.md
Name: twiddle_stream_sequencer

Overview:
- Streaming front-end and back-end for one radix-2 DIF stage multiplier of the 64-point FFT processor.
- Accepts butterfly-lower outputs with a sample index and computes the twiddle exponent for the configured stage.
- Drives A32, TYPESEL and the twiddle base index into the combinational complex multiplier block, then registers R32 into an output stream.
- Owns frame counting and valid/ready flow control around the multiplier.

Parameters:
- STAGE, 0, DIF stage number 0..5; twiddle exponent e = (IN_IDX mod (64>>STAGE)) << STAGE, taken mod 64.
- FRAME_LEN, 64, accepted samples per frame; FRAME_DONE is issued after this many.

Ports:
- CLK  input  1  single clock, rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input sample valid.
- IN_READY  output  1  sequencer can accept a sample.
- IN_DATA  input  32  {real[31:16], imag[15:0]}, Q1.15 two's complement.
- IN_IDX  input  6  sample index k within the frame.
- MUL_A32  output  32  registered operand to the multiplier A32.
- MUL_TYPESEL  output  3  octant select to the multiplier TYPESEL.
- MUL_BASE  output  3  twiddle base index e[2:0], selects the C_PLUS_S/C_ONLY/C_MIN_S constant set.
- MUL_R32  input  32  multiplier result, combinational from MUL_A32/MUL_TYPESEL/MUL_BASE.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- OUT_DATA  output  32  registered product.
- FRAME_DONE  output  1  one-cycle pulse when the last sample of a frame leaves on OUT.

Behaviour:
- Reset values: IN_READY=0; MUL_A32=0; MUL_TYPESEL=0; MUL_BASE=0; OUT_VALID=0; OUT_DATA=0; FRAME_DONE=0. The frame counter and both counters are cleared.
- Exponent mapping: e is 6 bits. MUL_TYPESEL = e[5:3] (octant). MUL_BASE = e[2:0].
- Pipeline, S1 (operand register):
  - An input transfer occurs when IN_VALID && IN_READY.
  - On a transfer, S1 loads MUL_A32=IN_DATA, MUL_TYPESEL, MUL_BASE and sets s1_valid.
- Pipeline, S2 (output register):
  - On S1→S2 advance, S2 loads OUT_DATA=MUL_R32 and sets OUT_VALID.
  - Latency is 2 cycles from the input transfer to OUT_VALID when there is no stall.
- Advance rules:
  - S2 loads when S1 is valid and (!OUT_VALID or OUT_READY).
  - S1 loads when S1 is empty or S1 is advancing.
  - IN_READY = state==RUN && (!s1_valid || s2_can_load).
  - Full throughput is 1 sample/cycle.
  - Backpressure holds OUT_DATA and the MUL_* outputs stable.
  - The MUL_* outputs only change on an S1 load.
- FSM states:
  - IDLE: entered on reset; moves to RUN the cycle after RSTN deasserts.
  - RUN: accepts input. When the input counter reaches FRAME_LEN-1 and a transfer occurs, moves to DRAIN.
  - DRAIN: IN_READY=0. When the last sample transfers on OUT, pulse FRAME_DONE, clear both counters and return to RUN.
- Counters:
  - in_cnt and out_cnt are 7 bits.
  - in_cnt wraps to 0 at FRAME_LEN.
  - IN_IDX is used for the exponent only; the sequencer does not check IN_IDX against in_cnt.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured, with no bubble.
- Reset mid-frame: all state is discarded immediately (asynchronous). No FRAME_DONE is issued for the partial frame.
- Boundaries:
  - e=0 gives TYPESEL=000, BASE=000, i.e. the multiplier applies W^0 = 1.
  - STAGE=5 gives e ∈ {0,32} only.

Optional Feature:
- Macro: TWIDDLE_STREAM_IFFT_CONJ_EN.
- When defined:
  - Adds input port INV (1 bit), sampled with each input transfer.
  - When INV=1, the exponent used is e' = (64 − e) mod 64, giving the conjugate twiddle for the IFFT.
  - TYPESEL and BASE are derived from e'.
- When undefined: the port is absent and e is always used unmodified.

Test Plan:
- STAGE=0, stream IN_IDX 0..63 with IN_DATA=32'h4000_0000 and OUT_READY=1 → OUT_VALID 2 cycles after each input. MUL_TYPESEL/MUL_BASE step 000/000..111/111 per k. FRAME_DONE pulses once, after the 64th output.
- STAGE=3, IN_IDX=13 → e=(13 mod 8)<<3=40, so MUL_TYPESEL=101, MUL_BASE=000.
- Hold OUT_READY=0 for 5 cycles while IN_VALID=1 → at most 2 samples are accepted and IN_READY drops. OUT_DATA is stable. After release, no samples are lost or duplicated and the order is preserved.
- Assert RSTN=0 mid-frame at sample 20 → all outputs return to reset values within the reset cycle. No FRAME_DONE. The next frame counts from 0.
- Apply input and output transfers every cycle for 3 frames → 1 sample/cycle sustained. FRAME_DONE occurs every frame, with a 2-cycle DRAIN gap at each frame boundary.
- With TWIDDLE_STREAM_IFFT_CONJ_EN, STAGE=0, IN_IDX=5, INV=1 → e'=59, so MUL_TYPESEL=111, MUL_BASE=011. With INV=0 → 000/101.
